// File: rtl/fsm_accum_ctrl.sv
// Command-driven accumulator controller: a four-state FSM gates the data_valid beats into a
// wrapping accumulator, counts the beats and aborts a stalled WAIT after TIMEOUT cycles.
module fsm_accum_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ACC_WIDTH  = 16,
   parameter int unsigned CNT_WIDTH  = 8,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [1:0]            cmd,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   output logic [1:0]            current_state,
   output logic [1:0]            next_state,
   output logic [ACC_WIDTH-1:0]  data_out,
   output logic                  valid_out,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout_err,
   output logic [CNT_WIDTH-1:0]  beat_count
);

   // The WAIT timer only has to reach TIMEOUT-1 before the FSM leaves WAIT.
   localparam int unsigned TMR_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] CMD_IDLE     = 2'b00;
   localparam logic [1:0] CMD_START    = 2'b01;
   localparam logic [1:0] CMD_WAIT     = 2'b10;
   localparam logic [1:0] CMD_COMPLETE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_PROCESS  = 2'b01,
      ST_WAIT     = 2'b10,
      ST_COMPLETE = 2'b11
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic                   start;
   logic                   beat;
   logic                   tmo;
   logic [ACC_WIDTH-1:0]   acc_q;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic [TMR_WIDTH-1:0]   timer_q;
   logic                   terr_q;
   logic                   valid_q;
   logic                   busy_q;
   logic                   done_q;

   // Next-state decode; with enable low every strobe stays low and the state holds.
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      beat    = 1'b0;
      tmo     = 1'b0;
      if (enable) begin
         case (state_q)
            ST_PROCESS: begin
               beat = data_valid;
               if (cmd == CMD_WAIT) begin
                  state_d = ST_WAIT;
               end else if (cmd == CMD_COMPLETE) begin
                  state_d = ST_COMPLETE;
               end
            end
            ST_WAIT: begin
               // An explicit command wins over the timeout in the same cycle.
               if (cmd == CMD_COMPLETE) begin
                  state_d = ST_COMPLETE;
               end else if (cmd == CMD_START) begin
                  state_d = ST_PROCESS;
               end else if (timer_q == TMR_WIDTH'(TIMEOUT - 1)) begin
                  state_d = ST_IDLE;
                  tmo     = 1'b1;
               end
            end
            ST_COMPLETE: begin
               if (cmd == CMD_IDLE) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               if (cmd == CMD_START) begin
                  state_d = ST_PROCESS;
                  start   = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         endcase
      end
   end

   // State register plus datapath; status flags are registered from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         timer_q <= '0;
         terr_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         valid_q <= (state_d == ST_COMPLETE);
         busy_q  <= (state_d == ST_PROCESS) || (state_d == ST_WAIT);
         done_q  <= (state_d == ST_IDLE);
         if (start) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            terr_q <= 1'b0;
         end else if (beat) begin
            acc_q <= acc_q + ACC_WIDTH'(data_in);
            if (cnt_q != '1) begin
               cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
         end
         if (tmo) begin
            terr_q <= 1'b1;
         end
         // Timer sits at zero outside WAIT, so it starts from zero on every entry.
         if (enable) begin
            if (state_q != ST_WAIT) begin
               timer_q <= '0;
            end else begin
               timer_q <= timer_q + TMR_WIDTH'(1);
            end
         end
      end
   end

   assign current_state = state_q;
   assign next_state    = state_d;
   assign data_out      = acc_q;
   assign beat_count    = cnt_q;
   assign timeout_err   = terr_q;
   assign valid_out     = valid_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule
